// File: rtl/uart_rx_word_ctrl_if.sv
// rtl/uart_rx_word_ctrl_if.sv - receiver and word-stream signals of uart_rx_word_ctrl
//
// Groups the link to uart_receiver (baud_select, RX_EN, Rx_DATA, Rx_VALID,
// Rx_FERROR, Rx_PERROR) with the downstream word handshake (word_data,
// word_valid, word_ready).
//   master: the word controller (drives receiver control and the word stream)
//   slave : the receiver plus word consumer side

interface uart_rx_word_ctrl_if #(
    parameter int BYTES_PER_WORD = 4
);
    logic [2:0]                    baud_select;
    logic                          RX_EN;
    logic [7:0]                    Rx_DATA;
    logic                          Rx_VALID;
    logic                          Rx_FERROR;
    logic                          Rx_PERROR;
    logic [8*BYTES_PER_WORD-1:0]   word_data;
    logic                          word_valid;
    logic                          word_ready;

    modport master (
        output baud_select, RX_EN, word_data, word_valid,
        input  Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR, word_ready
    );

    modport slave (
        input  baud_select, RX_EN, word_data, word_valid,
        output Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR, word_ready
    );
endinterface

// File: rtl/uart_rx_word_ctrl.sv
// rtl/uart_rx_word_ctrl.sv - sequences uart_receiver and assembles error-free bytes into words
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-low reset
//   cfg_enable   1 = run the receiver
//   cfg_baud     requested baud code, copied to baud_select while disabled
//   clr_flags    one-cycle pulse clearing err_count, overrun, timeout_flag
//   bus          uart_rx_word_ctrl_if.master: receiver control/status and word stream
//   err_count    saturating count of dropped bytes/words
//   overrun      sticky: byte or error arrived while a word was held
//   timeout_flag sticky: partial word dropped by the inter-byte timeout
//
// Optional feature: define UART_RX_WORD_CTRL_TIMEOUT_EN to build the
// inter-byte timeout; without it timeout_flag is tied low and partial words
// wait indefinitely.

module uart_rx_word_ctrl #(
    parameter int BYTES_PER_WORD = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_enable,
    input  logic [2:0]             cfg_baud,
    input  logic                   clr_flags,
    uart_rx_word_ctrl_if.master    bus,
    output logic [7:0]             err_count,
    output logic                   overrun,
    output logic                   timeout_flag
);

    localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(BYTES_PER_WORD - 1);

    typedef enum logic [1:0] {
        S_DISABLED = 2'd0,
        S_COLLECT  = 2'd1,
        S_HOLD     = 2'd2
    } state_t;

    state_t                        state;
    state_t                        state_next;
    logic [IDX_W-1:0]              byte_idx;
    logic [8*BYTES_PER_WORD-1:0]   word_q;
    logic [2:0]                    baud_q;

    // Receiver inputs are registered once; the second stage only remembers
    // the previous registered level for edge detection.
    logic [7:0] data_q;
    logic       valid_q;
    logic       valid_d;
    logic       err_q;
    logic       err_d;
    logic       err_event;
    logic       byte_event;
    logic       timeout_hit;

    // Control strobes from the FSM to the datapath.
    logic       store_byte;
    logic       clear_idx;
    logic       err_inc;
    logic       set_overrun;
    logic       set_timeout;

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            valid_d <= 1'b0;
            err_q   <= 1'b0;
            err_d   <= 1'b0;
        end else begin
            data_q  <= bus.Rx_DATA;
            valid_q <= bus.Rx_VALID;
            valid_d <= valid_q;
            err_q   <= bus.Rx_FERROR | bus.Rx_PERROR;
            err_d   <= err_q;
        end
    end

    // A byte that rises together with an error is treated as the error only.
    assign err_event  = err_q & ~err_d;
    assign byte_event = valid_q & ~valid_d & ~err_event;

`ifdef UART_RX_WORD_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] idle_cnt;
    logic             idle_run;

    assign timeout_hit = (idle_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Counts only while a partial word is pending and nothing else happened
    // this cycle; any byte, error, drop or state change restarts it.
    assign idle_run = (state == S_COLLECT) && cfg_enable && (byte_idx != '0)
                      && !err_event && !byte_event && !timeout_hit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (idle_run) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
        end else begin
            idle_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            timeout_flag <= 1'b0;
        end else if (clr_flags) begin
            timeout_flag <= 1'b0;
        end else if (set_timeout) begin
            timeout_flag <= 1'b1;
        end
    end
`else
    assign timeout_hit  = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_DISABLED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        store_byte  = 1'b0;
        clear_idx   = 1'b0;
        err_inc     = 1'b0;
        set_overrun = 1'b0;
        set_timeout = 1'b0;
        case (state)
            S_DISABLED: begin
                if (cfg_enable) begin
                    state_next = S_COLLECT;
                    clear_idx  = 1'b1;
                end
            end
            S_COLLECT: begin
                if (!cfg_enable) begin
                    state_next = S_DISABLED;
                    clear_idx  = 1'b1;
                end else if (err_event) begin
                    clear_idx = 1'b1;
                    err_inc   = 1'b1;
                end else if (byte_event) begin
                    store_byte = 1'b1;
                    if (byte_idx == LAST_LANE) begin
                        state_next = S_HOLD;
                        clear_idx  = 1'b1;
                    end
                end else if (timeout_hit) begin
                    clear_idx   = 1'b1;
                    err_inc     = 1'b1;
                    set_timeout = 1'b1;
                end
            end
            S_HOLD: begin
                // The held word is never touched here; late arrivals are lost.
                if (err_event || byte_event) begin
                    set_overrun = 1'b1;
                    err_inc     = 1'b1;
                end
                if (bus.word_ready) begin
                    state_next = cfg_enable ? S_COLLECT : S_DISABLED;
                    clear_idx  = 1'b1;
                end
            end
            default: begin
                state_next = S_DISABLED;
                clear_idx  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            byte_idx <= '0;
            word_q   <= '0;
            baud_q   <= 3'b000;
        end else begin
            if (store_byte) begin
                word_q[8*byte_idx +: 8] <= data_q;
            end
            if (clear_idx) begin
                byte_idx <= '0;
            end else if (store_byte) begin
                byte_idx <= byte_idx + IDX_W'(1);
            end
            // Baud code only follows the request while the receiver is off.
            if (state == S_DISABLED) begin
                baud_q <= cfg_baud;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_count <= 8'h00;
            overrun   <= 1'b0;
        end else if (clr_flags) begin
            err_count <= 8'h00;
            overrun   <= 1'b0;
        end else begin
            if (err_inc && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if (set_overrun) begin
                overrun <= 1'b1;
            end
        end
    end

    assign bus.RX_EN       = (state != S_DISABLED);
    assign bus.word_valid  = (state == S_HOLD);
    assign bus.word_data   = word_q;
    assign bus.baud_select = baud_q;

endmodule

// File: tb/tb_uart_rx_word_ctrl.sv
// tb/tb_uart_rx_word_ctrl.sv - self-checking bench for uart_rx_word_ctrl

module tb_uart_rx_word_ctrl;

    logic       clk;
    logic       reset;
    logic       cfg_enable;
    logic [2:0] cfg_baud;
    logic       clr_flags;
    logic [7:0] err_count;
    logic       overrun;
    logic       timeout_flag;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_word_ctrl_if #(.BYTES_PER_WORD(4)) bus ();

    uart_rx_word_ctrl #(
        .BYTES_PER_WORD (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_enable   (cfg_enable),
        .cfg_baud     (cfg_baud),
        .clr_flags    (clr_flags),
        .bus          (bus),
        .err_count    (err_count),
        .overrun      (overrun),
        .timeout_flag (timeout_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        perr;
        logic        ferr;
        logic        exp_valid;
        logic [31:0] exp_word;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge after the action edge.
    task automatic send_byte(input logic [7:0] d, input logic perr, input logic ferr);
        bus.Rx_DATA   = d;
        bus.Rx_VALID  = 1'b1;
        bus.Rx_PERROR = perr;
        bus.Rx_FERROR = ferr;
        @(negedge clk);
        bus.Rx_VALID  = 1'b0;
        bus.Rx_PERROR = 1'b0;
        bus.Rx_FERROR = 1'b0;
        @(negedge clk);
    endtask

    task automatic error_pulse(input logic with_clear);
        bus.Rx_FERROR = 1'b1;
        @(negedge clk);
        bus.Rx_FERROR = 1'b0;
        clr_flags     = with_clear;
        @(negedge clk);
        clr_flags     = 1'b0;
    endtask

    task automatic pulse_clear();
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            send_byte(w[8*b +: 8], 1'b0, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{8'hA1, 1'b0, 1'b0, 1'b0, 32'h0,        8'd0};
        vecs[1]  = '{8'h22, 1'b0, 1'b0, 1'b0, 32'h0,        8'd0};
        vecs[2]  = '{8'h33, 1'b0, 1'b0, 1'b0, 32'h0,        8'd0};
        vecs[3]  = '{8'h44, 1'b0, 1'b0, 1'b1, 32'h443322A1, 8'd0};
        vecs[4]  = '{8'h55, 1'b0, 1'b0, 1'b0, 32'h0,        8'd0};
        vecs[5]  = '{8'h66, 1'b1, 1'b0, 1'b0, 32'h0,        8'd1};
        vecs[6]  = '{8'h01, 1'b0, 1'b0, 1'b0, 32'h0,        8'd1};
        vecs[7]  = '{8'h02, 1'b0, 1'b0, 1'b0, 32'h0,        8'd1};
        vecs[8]  = '{8'h03, 1'b0, 1'b0, 1'b0, 32'h0,        8'd1};
        vecs[9]  = '{8'h04, 1'b0, 1'b0, 1'b1, 32'h04030201, 8'd1};
        vecs[10] = '{8'h77, 1'b0, 1'b1, 1'b0, 32'h0,        8'd2};

        reset          = 1'b0;
        cfg_enable     = 1'b0;
        cfg_baud       = 3'b111;
        clr_flags      = 1'b0;
        bus.Rx_DATA    = 8'h00;
        bus.Rx_VALID   = 1'b0;
        bus.Rx_FERROR  = 1'b0;
        bus.Rx_PERROR  = 1'b0;
        bus.word_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_baud", bus.baud_select, 3'b000);
        check("rst_rx_en", bus.RX_EN, 1'b0);
        check("rst_word_valid", bus.word_valid, 1'b0);
        check("rst_word_data", bus.word_data, 32'h0);
        check("rst_err_count", err_count, 8'd0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_timeout", timeout_flag, 1'b0);

        reset = 1'b1;
        @(negedge clk);
        check("dis_baud_load", bus.baud_select, 3'b111);
        check("dis_rx_en", bus.RX_EN, 1'b0);
        cfg_enable = 1'b1;
        @(negedge clk);
        check("en_rx_en", bus.RX_EN, 1'b1);
        cfg_baud = 3'b011;
        @(negedge clk);
        check("baud_frozen", bus.baud_select, 3'b111);

        // Normal word, parity-error resync, framing error
        for (int i = 0; i < 11; i++) begin
            send_byte(vecs[i].data, vecs[i].perr, vecs[i].ferr);
            check($sformatf("vec%0d_valid", i), bus.word_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_err", i), err_count, vecs[i].exp_err);
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_word", i), bus.word_data, vecs[i].exp_word);
                @(negedge clk);
                check($sformatf("vec%0d_valid_drop", i), bus.word_valid, 1'b0);
            end
        end
        pulse_clear();
        check("clr_err", err_count, 8'd0);

        // Backpressure with overrun
        bus.word_ready = 1'b0;
        send_word(32'hB4B3B2B1);
        check("bp_valid", bus.word_valid, 1'b1);
        send_byte(8'hEE, 1'b0, 1'b0);
        check("bp_word_kept", bus.word_data, 32'hB4B3B2B1);
        check("bp_valid_held", bus.word_valid, 1'b1);
        check("bp_overrun", overrun, 1'b1);
        check("bp_err", err_count, 8'd1);
        bus.word_ready = 1'b1;
        @(negedge clk);
        check("bp_transfer_once", bus.word_valid, 1'b0);
        send_word(32'hC4C3C2C1);
        check("bp_resume_valid", bus.word_valid, 1'b1);
        check("bp_resume_word", bus.word_data, 32'hC4C3C2C1);
        pulse_clear();
        check("bp_clr_overrun", overrun, 1'b0);
        check("bp_clr_err", err_count, 8'd0);

        // Inter-byte timeout
        send_byte(8'hD1, 1'b0, 1'b0);
        send_byte(8'hD2, 1'b0, 1'b0);
        repeat (120) @(negedge clk);
`ifdef UART_RX_WORD_CTRL_TIMEOUT_EN
        check("to_flag", timeout_flag, 1'b1);
        check("to_err", err_count, 8'd1);
        send_word(32'hE4E3E2E1);
        check("to_word_valid", bus.word_valid, 1'b1);
        check("to_word", bus.word_data, 32'hE4E3E2E1);
        pulse_clear();
        check("to_clr_flag", timeout_flag, 1'b0);
`else
        check("to_flag_tied", timeout_flag, 1'b0);
        check("to_valid_wait", bus.word_valid, 1'b0);
        send_byte(8'hD3, 1'b0, 1'b0);
        send_byte(8'hD4, 1'b0, 1'b0);
        check("to_word_valid", bus.word_valid, 1'b1);
        check("to_word", bus.word_data, 32'hD4D3D2D1);
        check("to_err", err_count, 8'd0);
`endif
        @(negedge clk);

        // Disable mid-word
        send_byte(8'hF1, 1'b0, 1'b0);
        send_byte(8'hF2, 1'b0, 1'b0);
        cfg_enable = 1'b0;
        @(negedge clk);
        check("dis_mid_rx_en", bus.RX_EN, 1'b0);
        cfg_baud = 3'b101;
        @(negedge clk);
        check("dis_mid_baud", bus.baud_select, 3'b101);
        cfg_enable = 1'b1;
        @(negedge clk);
        check("reen_rx_en", bus.RX_EN, 1'b1);
        send_word(32'h44332211);
        check("reen_valid", bus.word_valid, 1'b1);
        check("reen_word", bus.word_data, 32'h44332211);
        @(negedge clk);

        // Disable while holding keeps the word
        bus.word_ready = 1'b0;
        send_word(32'h9A9B9C9D);
        cfg_enable = 1'b0;
        repeat (2) @(negedge clk);
        check("hold_dis_valid", bus.word_valid, 1'b1);
        check("hold_dis_rx_en", bus.RX_EN, 1'b1);
        check("hold_dis_word", bus.word_data, 32'h9A9B9C9D);
        bus.word_ready = 1'b1;
        @(negedge clk);
        check("hold_dis_done_valid", bus.word_valid, 1'b0);
        check("hold_dis_done_rx_en", bus.RX_EN, 1'b0);
        cfg_enable = 1'b1;
        repeat (2) @(negedge clk);

        // Reset while holding a word with overrun set
        bus.word_ready = 1'b0;
        send_word(32'h5D5C5B5A);
        send_byte(8'h66, 1'b0, 1'b0);
        check("pre_rst_overrun", overrun, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", bus.word_valid, 1'b0);
        check("mid_rst_word", bus.word_data, 32'h0);
        check("mid_rst_rx_en", bus.RX_EN, 1'b0);
        check("mid_rst_baud", bus.baud_select, 3'b000);
        check("mid_rst_err", err_count, 8'd0);
        check("mid_rst_overrun", overrun, 1'b0);
        reset = 1'b1;
        bus.word_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_rx_en", bus.RX_EN, 1'b1);

        // Saturation and clear priority
        for (int i = 0; i < 255; i++) begin
            error_pulse(1'b0);
        end
        check("sat_255", err_count, 8'd255);
        error_pulse(1'b0);
        check("sat_256", err_count, 8'd255);
        pulse_clear();
        check("sat_clr", err_count, 8'd0);
        error_pulse(1'b1);
        check("clr_wins", err_count, 8'd0);
        error_pulse(1'b0);
        check("err_after_clr", err_count, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
